// File: rtl/floor_request_loader_if.sv
// Floor-request loader bundle: call inputs from the panel/controller side and
// the one-hot request word, LOAD strobe and occupancy status toward the slot bank.
interface floor_request_loader_if;
    logic [7:0] btn;
    logic [2:0] cur_floor;
    logic [7:0] served;
    logic       free;
    logic [7:0] req_out;
    logic       load;
    logic [7:0] pending;
    logic [2:0] slots_used;
    logic       full;

    modport master (
        output btn, cur_floor, served, free,
        input  req_out, load, pending, slots_used, full
    );

    modport slave (
        input  btn, cur_floor, served, free,
        output req_out, load, pending, slots_used, full
    );
endinterface

// File: rtl/floor_request_loader.sv
// Purpose: latch/dedup floor calls, feed them one at a time (one-hot word + LOAD) into a 4-slot bank; REQ_SYNC_EN adds a BTN synchronizer.
// Latency: press->PENDING 1 edge (3 with REQ_SYNC_EN); IDLE decision to LOAD high is 2 cycles, one load per 4 cycles.
// Backpressure: new loads are held in IDLE while all 4 slots are used; a load already started always completes.
module floor_request_loader (
    input  logic                   CLK,
    input  logic                   RESET,
    floor_request_loader_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [7:0] bs;
    logic [7:0] bs_q;
    logic [7:0] rise;
    logic [7:0] cur_oh;
    logic [7:0] cand;
    logic [7:0] cand_oh;
    logic [7:0] pending_q;
    logic [7:0] loaded_q;
    logic [7:0] req_q;
    logic       load_q;
    logic [2:0] slots_q;
    logic       full;
    logic       start;
    logic       slot_inc;
    logic       slot_dec;

`ifdef REQ_SYNC_EN
    logic [7:0] sync1_q;
    logic [7:0] sync2_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sync1_q <= 8'd0;
            sync2_q <= 8'd0;
        end else begin
            sync1_q <= bus.btn;
            sync2_q <= sync1_q;
        end
    end

    assign bs = sync2_q;
`else
    assign bs = bus.btn;
`endif

    assign rise   = bs & ~bs_q;
    assign cur_oh = 8'd1 << bus.cur_floor;
    assign full   = (slots_q == 3'd4);

    // A call for the floor the car is standing at is never loaded.
    assign cand    = pending_q & ~loaded_q & ~cur_oh;
    assign cand_oh = cand & (~cand + 8'd1);
    assign start   = (state_q == IDLE) && (cand != 8'd0) && !full;

    assign slot_inc = (state_q == STROBE);
    assign slot_dec = bus.free && (slots_q != 3'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= IDLE;
            bs_q      <= 8'd0;
            pending_q <= 8'd0;
            loaded_q  <= 8'd0;
            req_q     <= 8'd0;
            load_q    <= 1'b0;
            slots_q   <= 3'd0;
        end else begin
            state_q   <= state_d;
            bs_q      <= bs;
            // SERVED beats a same-cycle press and a same-cycle load of that floor.
            pending_q <= (pending_q | (rise & ~cur_oh)) & ~bus.served;
            loaded_q  <= (loaded_q | (start ? cand_oh : 8'd0)) & ~bus.served;
            if (start) begin
                req_q <= cand_oh;
            end
            load_q <= (state_q == SETUP);
            if (slot_inc && !bus.free) begin
                slots_q <= slots_q + 3'd1;
            end else if (!slot_inc && slot_dec) begin
                slots_q <= slots_q - 3'd1;
            end
        end
    end

    assign bus.req_out    = req_q;
    assign bus.load       = load_q;
    assign bus.pending    = pending_q;
    assign bus.slots_used = slots_q;
    assign bus.full       = full;

endmodule

// File: tb/tb_floor_request_loader.sv
// Bench for floor_request_loader: directed scenarios plus random traffic,
// every cycle compared against a request-level reference model.
module tb_floor_request_loader;

`ifdef REQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic reset;
    floor_request_loader_if bus();

    floor_request_loader dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: request sets, slot count and a countdown of the load sequence.
    logic [7:0] m_pending, m_loaded, m_req, m_bsq, m_s1, m_s2;
    int         m_slots, m_busy;

    int         cyc = 0;
    int         load_cnt;
    logic       prev_load;
    logic [7:0] load_reqs[$];
    int         load_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [7:0] bs, rise, oh, cand, pick;
        if (!reset) begin
            m_pending = 8'd0; m_loaded = 8'd0; m_req = 8'd0;
            m_bsq = 8'd0; m_s1 = 8'd0; m_s2 = 8'd0;
            m_slots = 0; m_busy = 0;
        end else begin
            bs = (LAT == 3) ? m_s2 : bus.btn;
            rise = bs & ~m_bsq;
            m_s2 = m_s1;
            m_s1 = bus.btn;
            m_bsq = bs;
            oh = 8'd1 << bus.cur_floor;
            cand = m_pending & ~m_loaded & ~oh;
            pick = 8'd0;
            if (m_busy == 0 && m_slots < 4) begin
                for (int i = 0; i < 8; i++) begin
                    if (cand[i] && pick == 8'd0) pick[i] = 1'b1;
                end
            end
            if (m_busy == 2) begin
                if (!bus.free) m_slots++;
            end else if (bus.free && m_slots > 0) begin
                m_slots--;
            end
            m_pending = (m_pending | (rise & ~oh)) & ~bus.served;
            m_loaded  = (m_loaded | pick) & ~bus.served;
            if (pick != 8'd0) begin
                m_req  = pick;
                m_busy = 3;
            end else if (m_busy > 0) begin
                m_busy--;
            end
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
            cyc++;
            chk("pending",    32'(bus.pending),    32'(m_pending));
            chk("req_out",    32'(bus.req_out),    32'(m_req));
            chk("load",       32'(bus.load),       32'(m_busy == 2));
            chk("slots_used", 32'(bus.slots_used), 32'(m_slots));
            chk("full",       32'(bus.full),       32'(m_slots == 4));
            if (bus.load === 1'b1 && prev_load !== 1'b1) begin
                load_cnt++;
                load_reqs.push_back(bus.req_out);
                load_cyc.push_back(cyc);
            end
            prev_load = bus.load;
        end
    endtask

    task automatic do_reset();
        bus.btn = 8'd0; bus.served = 8'd0; bus.free = 1'b0; bus.cur_floor = 3'd0;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        load_cnt = 0;
        load_reqs.delete();
        load_cyc.delete();
    endtask

    task automatic pulse_btn(input logic [7:0] b);
        bus.btn = b;
        tick(1);
        bus.btn = 8'd0;
    endtask

    // Bounded wait for the model to sit in the LOAD-high cycle with the given slot count.
    task automatic wait_strobe(input int slots, input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_busy == 2 && m_slots == slots) found = 1'b1;
            else tick(1);
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        prev_load = 1'b0;
        load_cnt = 0;
        do_reset();
        chk("rst_pending", 32'(bus.pending), 32'h0);
        chk("rst_req",     32'(bus.req_out), 32'h0);
        chk("rst_load",    32'(bus.load),    32'h0);
        chk("rst_slots",   32'(bus.slots_used), 32'h0);
        chk("rst_full",    32'(bus.full),    32'h0);

        // Single held press: one load only, press latency per build.
        bus.btn = 8'h08;
        for (int k = 1; k <= LAT; k++) begin
            tick(1);
            chk("press_latency", 32'(bus.pending), (k == LAT) ? 32'h08 : 32'h00);
        end
        tick(10 - LAT);
        bus.btn = 8'd0;
        tick(6);
        chk("single_loads",   32'(load_cnt),        32'd1);
        chk("single_req",     32'(bus.req_out),     32'h08);
        chk("single_slots",   32'(bus.slots_used),  32'd1);
        chk("single_pending", 32'(bus.pending),     32'h08);

        // Two simultaneous presses: lowest floor first, LOAD rises 4 cycles apart.
        do_reset();
        pulse_btn(8'h22);
        tick(20);
        chk("dual_loads", 32'(load_cnt), 32'd2);
        if (load_cnt == 2) begin
            chk("dual_req0", 32'(load_reqs[0]), 32'h02);
            chk("dual_req1", 32'(load_reqs[1]), 32'h20);
            chk("dual_gap",  32'(load_cyc[1] - load_cyc[0]), 32'd4);
        end
        chk("dual_slots", 32'(bus.slots_used), 32'd2);

        // Full stall, then one FREE lets a fifth request through.
        do_reset();
        pulse_btn(8'h7E);
        tick(30);
        chk("stall_loads", 32'(load_cnt), 32'd4);
        chk("stall_full",  32'(bus.full), 32'd1);
        chk("stall_load_low", 32'(bus.load), 32'd0);
        if (load_cnt == 4) begin
            chk("stall_req0", 32'(load_reqs[0]), 32'h02);
            chk("stall_req1", 32'(load_reqs[1]), 32'h04);
            chk("stall_req2", 32'(load_reqs[2]), 32'h08);
            chk("stall_req3", 32'(load_reqs[3]), 32'h10);
        end
        bus.free = 1'b1;
        tick(1);
        bus.free = 1'b0;
        tick(10);
        chk("free_loads", 32'(load_cnt),       32'd5);
        chk("free_req",   32'(bus.req_out),    32'h20);
        chk("free_slots", 32'(bus.slots_used), 32'd4);

        // Current-floor drop and dedup of a repeated press.
        do_reset();
        bus.cur_floor = 3'd3;
        pulse_btn(8'h08);
        tick(LAT + 2);
        chk("curfloor_drop", 32'(bus.pending), 32'h00);
        pulse_btn(8'h20);
        tick(3);
        pulse_btn(8'h20);
        tick(12);
        chk("dedup_loads", 32'(load_cnt), 32'd1);
        bus.served = 8'h20;
        tick(1);
        bus.served = 8'd0;
        chk("served_clear", 32'(bus.pending), 32'h00);
        pulse_btn(8'h20);
        tick(LAT + 8);
        chk("reload_loads", 32'(load_cnt), 32'd2);

        // SERVED in the cycle of the rise wins.
        do_reset();
        bus.btn = 8'h10;
        tick(LAT - 1);
        bus.served = 8'h10;
        tick(1);
        bus.served = 8'd0;
        chk("served_vs_rise", 32'(bus.pending), 32'h00);
        bus.btn = 8'd0;
        tick(2);

        // FREE coinciding with STROBE at two used slots.
        do_reset();
        pulse_btn(8'h06);
        tick(14);
        pulse_btn(8'h08);
        wait_strobe(2, "strobe_wait");
        bus.free = 1'b1;
        tick(1);
        bus.free = 1'b0;
        chk("free_vs_strobe", 32'(bus.slots_used), 32'd2);

        // Reset sampled during STROBE clears everything on that edge.
        do_reset();
        pulse_btn(8'h04);
        wait_strobe(0, "strobe_wait_rst");
        reset = 1'b0;
        tick(1);
        chk("midrst_load",    32'(bus.load),       32'd0);
        chk("midrst_req",     32'(bus.req_out),    32'h00);
        chk("midrst_pending", 32'(bus.pending),    32'h00);
        chk("midrst_slots",   32'(bus.slots_used), 32'd0);
        chk("midrst_full",    32'(bus.full),       32'd0);
        reset = 1'b1;
        tick(2);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) bus.btn = 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 19) == 0) bus.cur_floor = 3'($urandom_range(0, 7));
            bus.served = ($urandom_range(0, 7) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'd0;
            bus.free   = ($urandom_range(0, 5) == 0);
            reset      = ($urandom_range(0, 399) != 0);
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
